pipeline_trace_buffer: RTL and testbench



---
 rtl/pipeline_trace_buffer.sv | 147 ++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// Trace capture buffer for the 5-stage pipeline.
// Samples a TRACE_W slice into a circular buffer while armed, stops a
// programmable number of samples after a masked trigger match, then drains
// the captured window oldest-first over a valid/ready port.
module pipeline_trace_buffer #(
    parameter int TRACE_W = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               sample_en,
    input  logic [TRACE_W-1:0] trace_in,
    input  logic [TRACE_W-1:0] trig_ref,
    input  logic [TRACE_W-1:0] trig_mask,
    input  logic [CNT_W-1:0]   post_count,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [TRACE_W-1:0] rd_data,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic               triggered,
    output logic [CNT_W-1:0]   entries
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t curState, nextState;

    logic [TRACE_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wrPtr, rdPtr;
    logic [CNT_W-1:0]   postCnt, remaining;
    logic [CNT_W-1:0]   entriesInc, postLoad;
    logic               trigMatch, doWrite, doArm, doRead, trigHit, enterDrain;

    // Next-state decode and per-cycle action strobes
    always_comb begin
        nextState  = curState;
        doWrite    = 1'b0;
        doArm      = 1'b0;
        doRead     = 1'b0;
        trigHit    = 1'b0;
        trigMatch  = ((trace_in ^ trig_ref) & trig_mask) == '0;
        postLoad   = (post_count > POST_MAX) ? POST_MAX : post_count;
        entriesInc = (entries == DEPTH_C) ? entries : entries + 1'b1;
        if (abort) begin
            nextState = IDLE;
        end else begin
            case (curState)
                IDLE: begin
                    if (arm) begin
                        doArm     = 1'b1;
                        nextState = ARMED;
                    end
                end
                ARMED: begin
                    if (sample_en) begin
                        doWrite = 1'b1;
                        if (trigMatch) begin
                            trigHit   = 1'b1;
                            nextState = (postLoad == '0) ? DRAIN : POST;
                        end
                    end
                end
                POST: begin
                    if (sample_en) begin
                        doWrite = 1'b1;
                        if (postCnt == CNT_W'(1)) nextState = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        doRead = 1'b1;
                        if (remaining == CNT_W'(1)) nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
        enterDrain = (nextState == DRAIN) && (curState != DRAIN);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) curState <= IDLE;
        else     curState <= nextState;
    end

    // Pointers, counters and trigger flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            entries   <= '0;
            postCnt   <= '0;
            remaining <= '0;
            triggered <= 1'b0;
        end else begin
            if (doArm) begin
                wrPtr     <= '0;
                entries   <= '0;
                triggered <= 1'b0;
            end
            if (doWrite) begin
                wrPtr   <= wrPtr + AW'(1);
                entries <= entriesInc;
            end
            if (trigHit) begin
                triggered <= 1'b1;
                postCnt   <= postLoad;
            end else if (doWrite && curState == POST) begin
                postCnt <= postCnt - 1'b1;
            end
            // DRAIN is only entered on a write cycle, so the post-write
            // occupancy and write pointer set the window start.
            if (enterDrain) begin
                rdPtr     <= (entriesInc < DEPTH_C) ? '0 : wrPtr + AW'(1);
                remaining <= entriesInc;
            end
            if (doRead) begin
                rdPtr     <= rdPtr + AW'(1);
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr] <= trace_in;
    end

    assign state    = curState;
    assign rd_valid = (curState == DRAIN);
    assign rd_last  = rd_valid && (remaining == CNT_W'(1));
    assign rd_data  = mem[rdPtr];

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scoreboard bench for pipeline_trace_buffer: a queue-based capture model
// predicts each drained window; a negedge monitor checks the read port.
module tb_pipeline_trace_buffer;
    localparam int TW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst, arm, abort, sample_en, rd_ready;
    logic [TW-1:0] trace_in, trig_ref, trig_mask;
    logic [CW-1:0] post_count;
    logic          rd_valid, rd_last, triggered;
    logic [TW-1:0] rd_data;
    logic [1:0]    state;
    logic [CW-1:0] entries;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [TW-1:0] data;
        bit            last;
    } exp_t;

    exp_t          sbq[$];
    logic [TW-1:0] hist[$];
    int            mPhase, mPost, mRemain;
    bit            mTrig;
    logic [TW-1:0] v;

    always #5 clk = ~clk;

    pipeline_trace_buffer #(.TRACE_W(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .sample_en(sample_en),
        .trace_in(trace_in), .trig_ref(trig_ref), .trig_mask(trig_mask),
        .post_count(post_count), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .state(state),
        .triggered(triggered), .entries(entries)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic store(input logic [TW-1:0] d);
        hist.push_back(d);
        if (hist.size() > DEPTH) hist.delete(0);
    endtask

    task automatic startDrain();
        exp_t e;
        foreach (hist[i]) begin
            e.data = hist[i];
            e.last = (i == hist.size() - 1);
            sbq.push_back(e);
        end
        mRemain = hist.size();
        mPhase  = 3;
    endtask

    // Reference behaviour for one clock edge, from the inputs now applied
    task automatic modelEdge();
        if (abort) begin
            if (mPhase == 3) sbq.delete();
            mPhase = 0;
        end else begin
            case (mPhase)
                0: if (arm) begin hist.delete(); mTrig = 0; mPhase = 1; end
                1: if (sample_en) begin
                    store(trace_in);
                    if (((trace_in ^ trig_ref) & trig_mask) == 0) begin
                        mTrig = 1;
                        mPost = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                        if (mPost == 0) startDrain(); else mPhase = 2;
                    end
                end
                2: if (sample_en) begin
                    store(trace_in);
                    mPost--;
                    if (mPost == 0) startDrain();
                end
                3: if (rd_ready) begin
                    mRemain--;
                    if (mRemain == 0) mPhase = 0;
                end
                default: mPhase = 0;
            endcase
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
        check("state", 64'(state), 64'(mPhase));
        check("entries", 64'(entries), 64'(hist.size()));
        check("triggered", 64'(triggered), 64'(mTrig));
        check("rd_valid", 64'(rd_valid), 64'(mPhase == 3));
    endtask

    task automatic feed(input bit se, input logic [TW-1:0] d);
        sample_en = se;
        trace_in  = d;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic doArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic feedCount(input logic [TW-1:0] start);
        v = start;
        for (int n = 0; n < 200 && (mPhase == 1 || mPhase == 2); n++) begin
            feed(1'b1, v);
            v = v + 1;
        end
    endtask

    task automatic drain(input int holdFirst, input bit randomReady);
        for (int i = 0; i < holdFirst; i++) begin
            rd_ready = 1'b0;
            tick();
        end
        for (int n = 0; n < 200 && mPhase == 3; n++) begin
            rd_ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        check("sb_empty", 64'(sbq.size()), 64'(0));
    endtask

    // Read-port monitor, sampling mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_valid) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_read: rd_data=%0h with no expected entry at %0t", rd_data, $time);
                end else begin
                    check("rd_data", 64'(rd_data), 64'(sbq[0].data));
                    check("rd_last", 64'(rd_last), 64'(sbq[0].last));
                    if (rd_ready) sbq.delete(0);
                end
            end else if (!rst && rd_last) begin
                check("rd_last_idle", 64'(rd_last), 64'(0));
            end
        end
    end

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; rd_ready = 1'b0;
        trace_in = '0; trig_ref = '0; trig_mask = '0; post_count = '0;
        mPhase = 0; mPost = 0; mRemain = 0; mTrig = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(state), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_last", 64'(rd_last), 64'(0));
        check("rst_entries", 64'(entries), 64'(0));
        check("rst_triggered", 64'(triggered), 64'(0));
        rst = 1'b0;

        // Wrapped window with post-trigger samples
        trig_ref = 32'h10; trig_mask = '1; post_count = 4'd3;
        doArm();
        feedCount(32'h1);
        check("t1_state", 64'(state), 64'(3));
        check("t1_entries", 64'(entries), 64'(8));
        check("t1_head", 64'(rd_data), 64'(32'h0C));
        drain(0, 1'b0);
        check("t1_idle", 64'(state), 64'(0));

        // Early trigger, no wrap
        trig_ref = 32'h2; post_count = 4'd1;
        doArm();
        feedCount(32'h1);
        check("t2_entries", 64'(entries), 64'(3));
        check("t2_head", 64'(rd_data), 64'(32'h1));
        drain(0, 1'b1);

        // Masked trigger, post_count 0
        trig_ref = 32'h0000_4000; trig_mask = 32'h0000_FF00; post_count = 4'd0;
        doArm();
        feed(1'b1, 32'h1234_4100);
        check("t3_nofire", 64'(state), 64'(1));
        feed(1'b1, 32'h1234_4000);
        check("t3_fire", 64'(state), 64'(3));
        check("t3_entries", 64'(entries), 64'(2));
        drain(0, 1'b0);

        // Gapped sampling in POST, then held read port
        trig_ref = 32'h5; trig_mask = '1; post_count = 4'd4;
        doArm();
        for (int i = 1; i <= 5; i++) feed(1'b1, TW'(i));
        for (int i = 6; i < 40 && mPhase == 2; i++) feed(i[0] == 1'b0, TW'(i));
        check("t4_entries", 64'(entries), 64'(8));
        drain(5, 1'b0);

        // Abort and arm together in POST
        trig_ref = 32'h3; post_count = 4'd5;
        doArm();
        for (int i = 1; i <= 4; i++) feed(1'b1, TW'(i));
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("t5_state", 64'(state), 64'(0));
        check("t5_trig_kept", 64'(triggered), 64'(1));
        check("t5_entries_kept", 64'(entries), 64'(4));
        doArm();
        check("t5_rearm_trig", 64'(triggered), 64'(0));
        check("t5_rearm_entries", 64'(entries), 64'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset mid-drain, then clean recapture
        trig_ref = 32'h10; trig_mask = '1; post_count = 4'd3;
        doArm();
        feedCount(32'h1);
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_state", 64'(state), 64'(0));
        check("t6_rst_valid", 64'(rd_valid), 64'(0));
        check("t6_rst_entries", 64'(entries), 64'(0));
        check("t6_rst_trig", 64'(triggered), 64'(0));
        rst = 1'b0;
        mPhase = 0; mTrig = 0; hist.delete(); sbq.delete();
        trig_ref = 32'h4; post_count = 4'd2;
        doArm();
        feedCount(32'h1);
        check("t6_entries", 64'(entries), 64'(6));
        drain(2, 1'b1);

        // Randomised captures, including illegal post_count and stray arms
        for (int it = 0; it < 25; it++) begin
            trig_ref   = $urandom;
            trig_mask  = TW'($urandom_range(0, 7));
            post_count = CW'($urandom_range(0, 15));
            doArm();
            for (int n = 0; n < 300 && (mPhase == 1 || mPhase == 2); n++) begin
                arm       = ($urandom_range(0, 15) == 0);
                sample_en = ($urandom_range(0, 3) != 0);
                trace_in  = $urandom;
                tick();
                arm = 1'b0;
            end
            sample_en = 1'b0;
            if (mPhase != 3) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            drain($urandom_range(0, 3), 1'b1);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
